exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid  input  1  decoded operation offered.
REQ-004 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-005 exe_cmd  input  4  operation code: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR.
REQ-006 s_in  input  1  update status register with this operation's flags.
REQ-007 val1, val2  input  32 each  operands; val2 is the second (shifter) operand.
REQ-008 wb_en_in, dest_in  input  1, 4  writeback tag, passed through unmodified.
REQ-009 out_valid  output  1  result held; transfer when out_valid && out_ready.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 result, wb_en_out, dest_out  output  32, 1, 4  registered result and tag.
REQ-012 status  output  4  registered flags {N,Z,C,V}, bit 3 = N.

Function
REQ-013 Results SHALL be computed at input transfer and registered; latency is one cycle from transfer to out_valid.
REQ-014 MOV SHALL yield val2; MVN ~val2; AND/ORR/EOR bitwise on val1, val2.
REQ-015 ADD SHALL yield val1+val2; ADC val1+val2+C; SUB val1-val2; SBC val1-val2-1+C; all modulo 2^32.
REQ-016 The C used by ADC/SBC SHALL be the status register value, which already includes the update from the immediately preceding accepted operation.
REQ-017 Flags: N=result[31]; Z=(result==0); arithmetic C=carry-out of the 33-bit sum (subtraction: C=1 means no borrow); arithmetic V=signed overflow.
REQ-018 Logical ops and MOV/MVN SHALL update N,Z only; C,V unchanged.
REQ-019 Unlisted exe_cmd codes SHALL yield result 0 with no flag update regardless of s_in.
REQ-020 Status SHALL update on the input-transfer edge only when s_in=1; never on output transfer or stall.
REQ-021 Without skid: in_ready = !out_valid || out_ready; simultaneous output and input transfer SHALL replace the held result in the same edge with no bubble.
REQ-022 out_valid SHALL clear on output transfer with no new input transfer; held result and tag SHALL be stable while out_valid && !out_ready.

Reset
REQ-023 rst SHALL immediately clear out_valid, result, wb_en_out, dest_out, status to 0 and empty any buffer, including mid-stall; in-flight operations are discarded.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-025 Macro EXE_SKID_EN: when defined, a 2-entry output FIFO replaces the single register; in_ready SHALL be a register (=1 when fewer than 2 entries) with no combinational path from out_ready; order preserved; full and output transfer in the same cycle frees one slot next cycle.
REQ-026 Without EXE_SKID_EN, behaviour SHALL be exactly REQ-021/022.

Structure
REQ-027 Package exe_pkg SHALL hold exe_cmd code constants and flag bit indices (N=3, Z=2, C=1, V=0).
REQ-028 Sub-module exe_alu SHALL be purely combinational (cmd, operands, C in -> result, NZCV, flag-update mask); exe_stage holds handshake, status and buffering.

Verification
REQ-029 ADD 0x7FFFFFFF+1, s_in=1 -> result 0x80000000, status 1001 (N,V).
REQ-030 SUB 5-5, s_in=1, then ADC 1+1 -> 0, status 0110; ADC result 3.
REQ-031 SBC 0-0 with C=0, s_in=1 -> 0xFFFFFFFF, status 1000; AND with s_in=0 after -> status unchanged.
REQ-032 out_ready held 0 for 5 cycles with in_valid=1 -> result stable, in_ready=0 (no skid) or 0 after 2 accepts (EXE_SKID_EN); order preserved on release.
REQ-033 rst asserted mid-stall with out_valid=1 -> out_valid and status 0 without a clock edge; in_ready=1 after release.
REQ-034 Back-to-back accepts with out_ready=1 -> one result per cycle, no bubbles.

Source files
------------

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared constants and types for the execute stage
// Purpose: opcode encodings, NZCV flag bit positions, flag-update masks,
//          the buffered output entry type and a status merge helper.
// Ports:   none (package).
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Which status bits an operation is allowed to write
    localparam logic [3:0] MASK_ARITH = 4'b1111;
    localparam logic [3:0] MASK_LOGIC = 4'b1100;
    localparam logic [3:0] MASK_NONE  = 4'b0000;

    typedef struct packed {
        logic [31:0] result;
        logic        wb_en;
        logic [3:0]  dest;
    } exe_out_t;

    function automatic logic [3:0] merge_status(input logic [3:0] old_st,
                                                input logic [3:0] flags,
                                                input logic [3:0] mask);
        return (old_st & ~mask) | (flags & mask);
    endfunction

endpackage

// File: rtl/exe_alu.sv
// rtl/exe_alu.sv - combinational ALU for the execute stage
// Purpose: computes result, NZCV flags and the flag-update mask.
// Ports:   i_cmd (opcode), i_val1/i_val2 (operands), i_c (status C in),
//          o_result, o_flags {N,Z,C,V}, o_mask (bits the op may update).
module exe_alu
    import exe_pkg::*;
(
    input  logic [3:0]  i_cmd,
    input  logic [31:0] i_val1,
    input  logic [31:0] i_val2,
    input  logic        i_c,
    output logic [31:0] o_result,
    output logic [3:0]  o_flags,
    output logic [3:0]  o_mask
);

    logic [31:0] w_b;
    logic        w_cin;
    logic [32:0] w_sum;

    // Subtraction is val1 + ~val2 + cin so carry-out directly means "no borrow"
    always_comb begin
        w_b   = i_val2;
        w_cin = 1'b0;
        case (i_cmd)
            CMD_ADC: w_cin = i_c;
            CMD_SUB: begin w_b = ~i_val2; w_cin = 1'b1; end
            CMD_SBC: begin w_b = ~i_val2; w_cin = i_c;  end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, i_val1} + {1'b0, w_b} + {32'd0, w_cin};

    always_comb begin
        o_result = '0;
        o_mask   = MASK_NONE;
        case (i_cmd)
            CMD_MOV: begin o_result = i_val2;          o_mask = MASK_LOGIC; end
            CMD_MVN: begin o_result = ~i_val2;         o_mask = MASK_LOGIC; end
            CMD_AND: begin o_result = i_val1 & i_val2; o_mask = MASK_LOGIC; end
            CMD_ORR: begin o_result = i_val1 | i_val2; o_mask = MASK_LOGIC; end
            CMD_EOR: begin o_result = i_val1 ^ i_val2; o_mask = MASK_LOGIC; end
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                o_result = w_sum[31:0];
                o_mask   = MASK_ARITH;
            end
            default: ;
        endcase
        o_flags         = '0;
        o_flags[FLAG_N] = o_result[31];
        o_flags[FLAG_Z] = (o_result == 32'd0);
        o_flags[FLAG_C] = w_sum[32];
        // Overflow: both addends share a sign that the sum does not
        o_flags[FLAG_V] = (i_val1[31] == w_b[31]) && (w_sum[31] != i_val1[31]);
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage with valid/ready handshake and NZCV status
// Purpose: registers ALU results with their writeback tag, keeps the status
//          register, and buffers output. Optional macro EXE_SKID_EN selects a
//          2-entry output FIFO with a registered in_ready.
// Ports:   clk, rst (async, active-high); in_valid/in_ready, exe_cmd, s_in,
//          val1, val2, wb_en_in, dest_in (input side); out_valid/out_ready,
//          result, wb_en_out, dest_out (output side); status {N,Z,C,V}.
module exe_stage
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  exe_cmd,
    input  logic        s_in,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic        wb_en_in,
    input  logic [3:0]  dest_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        wb_en_out,
    output logic [3:0]  dest_out,
    output logic [3:0]  status
);

    logic [31:0] w_alu_result;
    logic [3:0]  w_alu_flags;
    logic [3:0]  w_alu_mask;
    logic        w_in_xfer;
    logic        w_out_xfer;
    exe_out_t    w_new;
    logic [3:0]  r_status;

    exe_alu u_alu (
        .i_cmd    (exe_cmd),
        .i_val1   (val1),
        .i_val2   (val2),
        .i_c      (r_status[FLAG_C]),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags),
        .o_mask   (w_alu_mask)
    );

    assign w_new      = {w_alu_result, wb_en_in, dest_in};
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign status     = r_status;

    // Status tracks accepted operations, so a following ADC/SBC sees the new C
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_status <= '0;
        else if (w_in_xfer && s_in)
            r_status <= merge_status(r_status, w_alu_flags, w_alu_mask);
    end

`ifdef EXE_SKID_EN
    exe_out_t   r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;
    logic       r_in_ready;
    logic [1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_in_xfer, w_out_xfer})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_in_xfer) begin
                r_mem[r_wr_ptr] <= w_new;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_out_xfer)
                r_rd_ptr <= ~r_rd_ptr;
            r_count    <= w_count_nxt;
            // Registered from the next occupancy: no path from out_ready
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    assign in_ready                      = r_in_ready;
    assign out_valid                     = (r_count != 2'd0);
    assign {result, wb_en_out, dest_out} = r_mem[r_rd_ptr];
`else
    exe_out_t r_out;
    logic     r_valid;

    // A draining result frees the register in the same cycle
    assign in_ready = !r_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_out   <= w_new;
            r_valid <= 1'b1;
        end else if (w_out_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid                     = r_valid;
    assign {result, wb_en_out, dest_out} = r_out;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking scoreboard bench for exe_stage
module tb_exe_stage;

`ifdef EXE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk, rst, in_valid, in_ready, s_in, wb_en_in, out_valid, out_ready, wb_en_out;
    logic [3:0]  exe_cmd, dest_in, dest_out, status;
    logic [31:0] val1, val2, result;

    exe_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .s_in(s_in), .val1(val1), .val2(val2),
        .wb_en_in(wb_en_in), .dest_in(dest_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .wb_en_out(wb_en_out),
        .dest_out(dest_out), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [36:0] sb[$];
    logic [3:0]  m_status = 4'b0000;
    logic        accepted, last_out;

    typedef struct {
        logic [3:0]  cmd;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  st;
    } op_t;

    op_t tab[14] = '{
        '{4'b0010, 1'b1, 32'h7FFFFFFF, 32'h00000001, 4'b1001},
        '{4'b0100, 1'b1, 32'h00000005, 32'h00000005, 4'b0110},
        '{4'b0011, 1'b1, 32'h00000001, 32'h00000001, 4'b0000},
        '{4'b0101, 1'b1, 32'h00000000, 32'h00000000, 4'b1000},
        '{4'b0110, 1'b0, 32'h0000F0F0, 32'h00000FF0, 4'b1000},
        '{4'b0010, 1'b1, 32'hFFFFFFFF, 32'h00000001, 4'b0110},
        '{4'b0001, 1'b1, 32'h12345678, 32'h00000000, 4'b0110},
        '{4'b1001, 1'b1, 32'h00000000, 32'h00000000, 4'b1010},
        '{4'b0111, 1'b1, 32'h00000000, 32'h00000000, 4'b0110},
        '{4'b1000, 1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF, 4'b0010},
        '{4'b1111, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010},
        '{4'b0010, 1'b1, 32'h80000000, 32'h80000000, 4'b0111},
        '{4'b0101, 1'b1, 32'h00000003, 32'h00000001, 4'b0010},
        '{4'b0100, 1'b1, 32'h00000001, 32'h00000002, 4'b1000}
    };

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: 64-bit unsigned/signed arithmetic, independent of the ALU datapath
    task automatic model(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r);
        logic [63:0] ua, ub, w;
        longint      sa, sb_, sr;
        logic        c, v, cold;
        int          kind;
        cold = m_status[1];
        ua = {32'd0, a}; ub = {32'd0, b};
        sa = longint'($signed(a)); sb_ = longint'($signed(b));
        w = '0; sr = 0; c = 1'b0; v = 1'b0; kind = 1; r = '0;
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            4'b0010: begin kind = 2; w = ua + ub; c = w[32]; sr = sa + sb_; end
            4'b0011: begin kind = 2; w = ua + ub + {63'd0, cold}; c = w[32];
                           sr = sa + sb_ + (cold ? 64'sd1 : 64'sd0); end
            4'b0100: begin kind = 2; w = ua - ub; c = (ua >= ub); sr = sa - sb_; end
            4'b0101: begin kind = 2; w = ua - ub - 64'd1 + {63'd0, cold};
                           c = (ua + {63'd0, cold} >= ub + 64'd1);
                           sr = sa - sb_ - (cold ? 64'sd0 : 64'sd1); end
            default: kind = 0;
        endcase
        if (kind == 2) begin
            r = w[31:0];
            v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end
        if (s && kind != 0) begin
            m_status[3] = r[31];
            m_status[2] = (r == 32'd0);
            if (kind == 2) begin
                m_status[1] = c;
                m_status[0] = v;
            end
        end
    endtask

    // One clock: inputs already driven at negedge; handshake sampled 1ns later
    task automatic cycle();
        logic [31:0] r;
        logic [36:0] e;
        #1;
        accepted = 1'b0;
        last_out = 1'b0;
        if (out_valid && out_ready) begin
            last_out = 1'b1;
            if (sb.size() == 0) chk("unexpected_output", 37'd1, 37'd0);
            else begin
                e = sb.pop_front();
                chk("out_data", {result, wb_en_out, dest_out}, e);
            end
        end
        if (in_valid && in_ready) begin
            model(exe_cmd, s_in, val1, val2, r);
            sb.push_back({r, wb_en_in, dest_in});
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("status", {33'd0, status}, {33'd0, m_status});
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int id);
        in_valid = 1'b1; exe_cmd = cmd; s_in = s; val1 = a; val2 = b;
        wb_en_in = id[0]; dest_in = id[3:0];
    endtask

    task automatic send(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int id);
        int budget = 20;
        drive(cmd, s, a, b, id);
        do begin
            cycle();
            budget--;
        end while (!accepted && budget > 0);
        if (!accepted) chk("accept_timeout", 37'd0, 37'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 20;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && budget > 0) begin
            cycle();
            budget--;
        end
        chk("drain_left", 37'(sb.size()), 37'd0);
        chk("drained_valid", {36'd0, out_valid}, 37'd0);
    endtask

    initial begin
        int k;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; exe_cmd = '0; s_in = 1'b0;
        val1 = '0; val2 = '0; wb_en_in = 1'b0; dest_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {36'd0, out_valid}, 37'd0);
        chk("rst_outputs", {result, wb_en_out, dest_out}, 37'd0);
        chk("rst_status", {33'd0, status}, 37'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {36'd0, in_ready}, 37'd1);

        // Back-to-back burst with out_ready=1
        for (int i = 0; i < 14; i++) begin
            send(tab[i].cmd, tab[i].s, tab[i].a, tab[i].b, i);
            chk("tab_status", {33'd0, status}, {33'd0, tab[i].st});
            if (i > 0) chk("no_bubble", {36'd0, last_out}, 37'd1);
        end
        drain();

        // Stall: out_ready low for 5 cycles while offering operations
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            drive(4'b0010, 1'b0, 32'd100 + 32'(k), 32'd7, 8 + k);
            #1;
            chk("stall_in_ready", {36'd0, in_ready},
                {36'd0, (SKID ? (c < 2) : (c < 1))});
            if (out_valid) chk("stall_hold", {result, wb_en_out, dest_out}, sb[0]);
            cycle();
            if (accepted) k++;
        end
        chk("stall_accepts", 37'(k), SKID ? 37'd2 : 37'd1);
        drain();

        // Reset in the middle of a stall
        out_ready = 1'b0;
        send(4'b1001, 1'b1, 32'd0, 32'd0, 5);
        chk("pre_rst_valid", {36'd0, out_valid}, 37'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", {36'd0, out_valid}, 37'd0);
        chk("async_rst_status", {33'd0, status}, 37'd0);
        chk("async_rst_outputs", {result, wb_en_out, dest_out}, 37'd0);
        sb.delete();
        m_status = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_mid_rst", {36'd0, in_ready}, 37'd1);
        out_ready = 1'b1;
        send(4'b0011, 1'b1, 32'd2, 32'd3, 3);
        send(4'b0100, 1'b1, 32'd9, 32'd4, 4);
        drain();
        chk("final_status", {33'd0, status}, 37'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
